// File: rtl/poly_draw_sequencer_pkg.sv
// Shared definitions for the polygon draw sequencer, the polygon drawer and the
// game-state logic: FSM encoding, entity class IDs and default sizing.
package poly_draw_sequencer_pkg;

    localparam int DEF_NUM_CLASSES   = 3;
    localparam int DEF_MAX_PER_CLASS = 16;
    localparam int DEF_TIMEOUT       = 4096;

    localparam int SHIP     = 0;
    localparam int ASTEROID = 1;
    localparam int SHOT     = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ROUTE = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } pds_state_e;

    // Width helper that never returns zero, so degenerate sizes still give legal vectors.
    function automatic int clog2_min1(input int value);
        return (value < 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/poly_draw_sequencer_if.sv
// Frame-control and drawer handshake bundle between the game-state logic,
// the draw sequencer (master) and the polygon drawer side (slave).
interface poly_draw_sequencer_if
    import poly_draw_sequencer_pkg::*;
#(
    parameter int NUM_CLASSES   = DEF_NUM_CLASSES,
    parameter int MAX_PER_CLASS = DEF_MAX_PER_CLASS
);
    localparam int CW  = clog2_min1(NUM_CLASSES);
    localparam int IW  = clog2_min1(MAX_PER_CLASS + 1);
    localparam int DIW = (IW > 1) ? IW - 1 : 1;
    localparam int NW  = clog2_min1(NUM_CLASSES * MAX_PER_CLASS + 1);

    logic                               frame_start;
    logic [NUM_CLASSES*IW-1:0]          class_count;
    logic [NUM_CLASSES*MAX_PER_CLASS-1:0] active_mask;
    logic                               draw_done;
    logic                               draw_start;
    logic [CW-1:0]                      draw_class;
    logic [DIW-1:0]                     draw_index;
    logic                               busy;
    logic                               frame_done;
    logic [NW-1:0]                      drawn_count;
    logic                               timeout_err;

    modport master (
        input  frame_start, class_count, active_mask, draw_done,
        output draw_start, draw_class, draw_index, busy, frame_done, drawn_count, timeout_err
    );

    modport slave (
        output frame_start, class_count, active_mask, draw_done,
        input  draw_start, draw_class, draw_index, busy, frame_done, drawn_count, timeout_err
    );

endinterface

// File: rtl/poly_draw_sequencer_wait_timer.sv
// Per-entity wait timer: saturating counter that flags expiry on its
// TIMEOUT-th enabled cycle after a clear. TIMEOUT of 0 never expires.
module pds_wait_timer
    import poly_draw_sequencer_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int            TW    = clog2_min1(TIMEOUT + 1);
    localparam logic [TW-1:0] LIMIT = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    logic [TW-1:0] count_q, count_d;

    // Holding at LIMIT keeps the count from wrapping during a long stall.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (TIMEOUT > 0) && (count_q == LIMIT);

endmodule

// File: rtl/poly_draw_sequencer.sv
// Walks every live entity slot class by class, hands each to the polygon drawer
// and waits for completion (or a timeout) before moving on.
module poly_draw_sequencer
    import poly_draw_sequencer_pkg::*;
#(
    parameter int NUM_CLASSES   = DEF_NUM_CLASSES,
    parameter int MAX_PER_CLASS = DEF_MAX_PER_CLASS,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input logic                   clk,
    input logic                   reset,
    poly_draw_sequencer_if.master bus
);
    localparam int CW  = clog2_min1(NUM_CLASSES);
    localparam int CXW = CW + 1;
    localparam int IW  = clog2_min1(MAX_PER_CLASS + 1);
    localparam int DIW = (IW > 1) ? IW - 1 : 1;
    localparam int NW  = clog2_min1(NUM_CLASSES * MAX_PER_CLASS + 1);
    localparam int BW  = clog2_min1(NUM_CLASSES * MAX_PER_CLASS);

    localparam logic [CXW-1:0] LAST_CLASS = CXW'(NUM_CLASSES);
    localparam logic [IW-1:0]  MAX_COUNT  = IW'(MAX_PER_CLASS);
    localparam logic [NW-1:0]  DRAWN_MAX  = NW'(NUM_CLASSES * MAX_PER_CLASS);

    pds_state_e     state_q, state_d;
    logic [CXW-1:0] class_q, class_d;
    logic [IW-1:0]  index_q, index_d;
    logic [IW-1:0]  count_q [NUM_CLASSES];
    logic [IW-1:0]  count_d [NUM_CLASSES];
    logic [IW-1:0]  count_clamped [NUM_CLASSES];
    logic [NW-1:0]  drawn_q, drawn_d;
    logic           timeout_err_q, timeout_err_d;
    logic [IW-1:0]  cur_count;
    logic [BW-1:0]  cur_bit;
    logic           cur_active;
    logic           timer_expired;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_clamp
            assign count_clamped[gi] = (bus.class_count[gi*IW +: IW] > MAX_COUNT)
                                     ? MAX_COUNT : bus.class_count[gi*IW +: IW];
        end
    endgenerate

    // Only read while class_q < NUM_CLASSES; the DONE test in ROUTE has priority.
    assign cur_count  = count_q[class_q[CW-1:0]];
    assign cur_bit    = BW'(int'(class_q) * MAX_PER_CLASS + int'(index_q));
    assign cur_active = bus.active_mask[cur_bit];

    pds_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_q == ST_START),
        .en_i      (state_q == ST_WAIT),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            class_q       <= '0;
            index_q       <= '0;
            drawn_q       <= '0;
            timeout_err_q <= 1'b0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                count_q[c] <= '0;
            end
        end else begin
            state_q       <= state_d;
            class_q       <= class_d;
            index_q       <= index_d;
            drawn_q       <= drawn_d;
            timeout_err_q <= timeout_err_d;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                count_q[c] <= count_d[c];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        class_d       = class_q;
        index_d       = index_q;
        drawn_d       = drawn_q;
        timeout_err_d = timeout_err_q;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            count_d[c] = count_q[c];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.frame_start) begin
                    for (int c = 0; c < NUM_CLASSES; c++) begin
                        count_d[c] = count_clamped[c];
                    end
                    class_d       = '0;
                    index_d       = '0;
                    drawn_d       = '0;
                    timeout_err_d = 1'b0;
                    state_d       = ST_ROUTE;
                end
            end
            ST_ROUTE: begin
                if (class_q == LAST_CLASS) begin
                    state_d = ST_DONE;
                end else if (index_q >= cur_count) begin
                    class_d = class_q + 1'b1;
                    index_d = '0;
                end else if (!cur_active) begin
                    index_d = index_q + 1'b1;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                // A completion in the expiry cycle still counts as drawn.
                if (bus.draw_done) begin
                    if (drawn_q != DRAWN_MAX) begin
                        drawn_d = drawn_q + 1'b1;
                    end
                    state_d = ST_NEXT;
                end else if (timer_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_NEXT;
                end
            end
            ST_NEXT: begin
                index_d = index_q + 1'b1;
                state_d = ST_ROUTE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.draw_start = (state_q == ST_START);
        bus.busy       = (state_q != ST_IDLE);
        bus.frame_done = (state_q == ST_DONE);
    end

    assign bus.draw_class  = CW'(class_q);
    assign bus.draw_index  = DIW'(index_q);
    assign bus.drawn_count = drawn_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_poly_draw_sequencer.sv
// Randomized scoreboard bench: a pass planner predicts draws, drawn count, error
// flag and pass length; a drawer model answers draw_start; a monitor checks.
module tb_poly_draw_sequencer;

    localparam int NUMC = 3;
    localparam int MAXP = 16;
    localparam int TMO  = 8;
    localparam int IW   = 5;
    localparam int MW   = NUMC * MAXP;
    localparam logic [MW-1:0] ALL_LIVE = '1;

    typedef struct {
        int cls;
        int idx;
    } draw_t;

    typedef struct {
        int drawn;
        int terr;
        int lat;
        int ndraw;
    } frame_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    poly_draw_sequencer_if #(.NUM_CLASSES(NUMC), .MAX_PER_CLASS(MAXP)) bus ();

    poly_draw_sequencer #(
        .NUM_CLASSES   (NUMC),
        .MAX_PER_CLASS (MAXP),
        .TIMEOUT       (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    draw_t  draw_exp_q[$];
    int     delay_q[$];
    frame_t frame_exp_q[$];
    int     n_vec = 0;
    int     n_mis = 0;
    int     pass_no = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        n_vec++;
        n_mis++;
        $display("FAIL %s: event not expected by scoreboard", name);
    endtask

    function automatic logic [NUMC*IW-1:0] pack_counts(input int a, input int b, input int c);
        logic [NUMC*IW-1:0] v;
        v[0*IW +: IW] = IW'(a);
        v[1*IW +: IW] = IW'(b);
        v[2*IW +: IW] = IW'(c);
        return v;
    endfunction

    // Mostly in-time completions (including the expiry cycle), sometimes late ones.
    function automatic int rand_delay();
        if ($urandom_range(0, 9) == 0) return 9 + int'($urandom_range(0, 1));
        return int'($urandom_range(1, TMO));
    endfunction

    // Reference model: one pass over the slots, in class then index order.
    task automatic plan_pass(input int a, input int b, input int c,
                             input logic [MW-1:0] mask, input int dfix);
        int cnt[3];
        frame_t f;
        draw_t e;
        int routes, n, d;
        cnt[0] = a; cnt[1] = b; cnt[2] = c;
        f.drawn = 0; f.terr = 0; f.ndraw = 0; f.lat = 1;
        routes = 1;
        for (int k = 0; k < NUMC; k++) begin
            n = (cnt[k] > MAXP) ? MAXP : cnt[k];
            routes += n + 1;
            for (int i = 0; i < n; i++) begin
                if (mask[k*MAXP + i]) begin
                    d = (dfix > 0) ? dfix : rand_delay();
                    e.cls = k;
                    e.idx = i;
                    draw_exp_q.push_back(e);
                    delay_q.push_back(d);
                    f.ndraw++;
                    if (d <= TMO) begin
                        f.drawn++;
                        f.lat += 2 + d;
                    end else begin
                        f.terr = 1;
                        f.lat += 2 + TMO;
                    end
                end
            end
        end
        f.lat += routes;
        if (f.drawn > MW) f.drawn = MW;
        frame_exp_q.push_back(f);
    endtask

    task automatic finish_now();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    endtask

    task automatic run_pass(input int a, input int b, input int c,
                            input logic [MW-1:0] mask, input int dfix, input bit spur);
        int n;
        bit seen;
        plan_pass(a, b, c, mask, dfix);
        bus.class_count = pack_counts(a, b, c);
        bus.active_mask = mask;
        bus.frame_start = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 4000) begin
            @(negedge clk);
            n++;
            bus.frame_start = 1'b0;
            if (bus.frame_done) begin
                seen = 1'b1;
            end else if (spur && bus.busy && $urandom_range(0, 15) == 0) begin
                bus.frame_start = 1'b1;
                bus.class_count = pack_counts(int'($urandom_range(0, 31)),
                                              int'($urandom_range(0, 31)),
                                              int'($urandom_range(0, 31)));
            end
        end
        if (!seen) begin
            $display("FAIL pass_timeout: got no frame_done, expected one within 4000 cycles");
            n_vec++;
            n_mis++;
            finish_now();
        end
        @(negedge clk);
    endtask

    // Drawer model: answers each draw_start with a one-cycle draw_done after its planned delay.
    initial begin
        int left;
        left = 0;
        bus.draw_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.draw_done = 1'b0;
            if (left > 0) begin
                left--;
                if (left == 0) bus.draw_done = 1'b1;
            end
            if (bus.draw_start) begin
                if (delay_q.size() > 0) left = delay_q.pop_front();
                else miss("drawer_delay");
            end
        end
    end

    // Monitor: compares every draw_start and frame_done against the scoreboard.
    initial begin
        int cyc, start_cyc, held;
        bit chk_clear, chk_hold;
        draw_t e;
        frame_t f;
        cyc = 0; start_cyc = 0; held = 0;
        chk_clear = 1'b0; chk_hold = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (reset) begin
                chk_clear = 1'b0;
                chk_hold  = 1'b0;
            end else begin
                if (chk_clear) begin
                    check("start_clears_drawn", bus.drawn_count, 0);
                    check("start_clears_terr", bus.timeout_err, 0);
                    chk_clear = 1'b0;
                end
                if (chk_hold) begin
                    check("idle_drawn_hold", bus.drawn_count, held);
                    check("idle_busy", bus.busy, 0);
                    chk_hold = 1'b0;
                end
                if (bus.draw_start) begin
                    if (draw_exp_q.size() == 0) begin
                        miss("draw_start");
                    end else begin
                        e = draw_exp_q.pop_front();
                        check("draw_class", bus.draw_class, e.cls);
                        check("draw_index", bus.draw_index, e.idx);
                    end
                end
                if (bus.frame_done) begin
                    if (frame_exp_q.size() == 0) begin
                        miss("frame_done");
                    end else begin
                        f = frame_exp_q.pop_front();
                        pass_no++;
                        $display("pass %0d: draws=%0d drawn=%0d terr=%0d cycles=%0d",
                                 pass_no, f.ndraw, bus.drawn_count, bus.timeout_err, cyc - start_cyc);
                        check("drawn_count", bus.drawn_count, f.drawn);
                        check("timeout_err", bus.timeout_err, f.terr);
                        check("pass_cycles", cyc - start_cyc, f.lat);
                        check("draws_missing", draw_exp_q.size(), 0);
                        held = f.drawn;
                        chk_hold = 1'b1;
                    end
                end
                if (bus.frame_start && !bus.busy) begin
                    start_cyc = cyc;
                    chk_clear = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [63:0] r;
        int n;
        bit activity;
        reset = 1'b1;
        bus.frame_start = 1'b0;
        bus.class_count = '0;
        bus.active_mask = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_draw_start", bus.draw_start, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_draw_class", bus.draw_class, 0);
        check("rst_draw_index", bus.draw_index, 0);
        check("rst_drawn_count", bus.drawn_count, 0);
        check("rst_timeout_err", bus.timeout_err, 0);
        reset = 1'b0;
        @(negedge clk);

        run_pass(1, 3, 2, ALL_LIVE, 5, 1'b0);
        run_pass(0, 4, 0, 48'h0000_000A_0000, 0, 1'b0);
        run_pass(1, 0, 0, ALL_LIVE, 9, 1'b0);
        run_pass(1, 0, 0, ALL_LIVE, 10, 1'b0);
        run_pass(1, 0, 0, ALL_LIVE, 8, 1'b0);
        run_pass(1, 0, 0, ALL_LIVE, 7, 1'b0);
        run_pass(20, 0, 0, ALL_LIVE, 0, 1'b1);
        run_pass(0, 0, 0, ALL_LIVE, 0, 1'b1);
        run_pass(16, 16, 16, ALL_LIVE, 1, 1'b1);

        for (int p = 0; p < 30; p++) begin
            r = {$urandom, $urandom};
            run_pass(int'($urandom_range(0, 24)), int'($urandom_range(0, 24)),
                     int'($urandom_range(0, 24)), r[MW-1:0], 0, 1'b1);
        end

        // Abort a pass two cycles after its draw_start; the late draw_done must do nothing.
        plan_pass(1, 0, 0, ALL_LIVE, 6);
        void'(frame_exp_q.pop_back());
        bus.class_count = pack_counts(1, 0, 0);
        bus.active_mask = ALL_LIVE;
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        n = 0;
        while (!bus.draw_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_saw_draw_start", bus.draw_start, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_draw_start", bus.draw_start, 0);
        check("abort_drawn_count", bus.drawn_count, 0);
        check("abort_timeout_err", bus.timeout_err, 0);
        activity = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.busy || bus.draw_start || bus.frame_done) activity = 1'b1;
        end
        check("abort_late_done_activity", activity, 0);
        check("scoreboard_leftover", draw_exp_q.size() + delay_q.size() + frame_exp_q.size(), 0);
        finish_now();
    end

endmodule

// File: doc/poly_draw_sequencer.md
POLY_DRAW_SEQUENCER -- requirements
Module: poly_draw_sequencer

Interface
REQ-001 Param NUM_CLASSES, default 3: entity classes, drawn in class order 0 to NUM_CLASSES-1 (0=ship, 1=asteroid, 2=shot).
REQ-002 Param MAX_PER_CLASS, default 16: entity slots per class.
REQ-003 Param TIMEOUT, default 4096: max WAIT cycles per entity; 0 disables the timeout.
REQ-004 Derived widths: CW=clog2(NUM_CLASSES), IW=clog2(MAX_PER_CLASS+1), NW=clog2(NUM_CLASSES*MAX_PER_CLASS+1).
REQ-005 Ports, in order: name, direction, width, meaning.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 frame_start  in  1  pulse; begins one draw pass.
REQ-009 class_count  in  NUM_CLASSES*IW  packed per-class entity count, class c at [c*IW +: IW].
REQ-010 active_mask  in  NUM_CLASSES*MAX_PER_CLASS  bit c*MAX_PER_CLASS+i set means entity (c,i) is live.
REQ-011 draw_done  in  1  pulse from the polygon drawer; current entity finished.
REQ-012 draw_start  out  1  one-cycle pulse; request to draw the entity (draw_class, draw_index).
REQ-013 draw_class  out  CW  and draw_index  out  IW-1 (min 1)  identify the entity; stable from draw_start until leaving WAIT.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 frame_done  out  1  one-cycle pulse at the end of a pass.
REQ-016 drawn_count  out  NW  entities completed with draw_done in the last or current pass.
REQ-017 timeout_err  out  1  sticky; set on any timeout; cleared by reset or frame_start.

Function
REQ-018 FSM states: IDLE, ROUTE, START, WAIT, NEXT, DONE.
REQ-019 IDLE: on frame_start, latch class_count clamped to MAX_PER_CLASS, clear class/index counters, drawn_count and timeout_err, then go to ROUTE.
REQ-020 frame_start outside IDLE is ignored and has no side effects.
REQ-021 ROUTE, evaluated in priority order:
- class==NUM_CLASSES -> DONE.
- index>=latched count[class] -> class+1, index=0, stay in ROUTE.
- active bit clear -> index+1, stay in ROUTE.
- otherwise -> START.
REQ-022 active_mask is sampled live in ROUTE; class_count is used only as latched at frame_start.
REQ-023 START: draw_start=1 for exactly this cycle; clear the wait timer; go to WAIT.
REQ-024 WAIT:
- draw_done -> NEXT and increment drawn_count.
- timer reaches TIMEOUT-1 without draw_done -> set timeout_err, go to NEXT, drawn_count unchanged.
- draw_done and timer expiry in the same cycle: draw_done wins.
REQ-025 NEXT: index+1, then ROUTE.
REQ-026 draw_done in any state other than WAIT is ignored.
REQ-027 DONE: frame_done=1 for one cycle, then IDLE. drawn_count holds until the next frame_start.
REQ-028 Counts of zero for all classes give a pass of ROUTE(x NUM_CLASSES+1) then DONE, with no draw_start.
REQ-029 Minimum cost per drawn entity: START, WAIT(>=1), NEXT, ROUTE, i.e. 4 cycles. A skipped slot costs 1 cycle.
REQ-030 drawn_count saturates at NUM_CLASSES*MAX_PER_CLASS. The wait timer saturates and does not wrap.

Reset
REQ-031 reset, sampled at a rising edge, forces:
- state=IDLE
- draw_start=0, frame_done=0, busy=0
- draw_class=0, draw_index=0
- drawn_count=0, timeout_err=0
- all internal counters and latched counts cleared.
REQ-032 Reset mid-pass aborts the pass immediately with no frame_done. Pending draw_done pulses after reset are ignored.

Structure
REQ-033 A shared package holds the FSM state encoding, the class-ID constants (SHIP=0, ASTEROID=1, SHOT=2) and the default parameter values. The polygon drawer and the game-state logic import the same package.
REQ-034 One sub-module: pds_wait_timer. It is a saturating counter with clear and enable inputs, a compare to TIMEOUT, and an expired output. Everything else stays in the top module.

Verification
REQ-035 Counts {1,3,2}, all active, draw_done 5 cycles after each draw_start:
- 6 draw_start pulses, in order (0,0), (1,0), (1,1), (1,2), (2,0), (2,1).
- frame_done once; drawn_count=6; timeout_err=0.
REQ-036 Counts {0,4,0}, active_mask for class 1 = 0b1010:
- draws only (1,1) and (1,3).
- drawn_count=2.
REQ-037 TIMEOUT=8, counts {1,0,0}, draw_done never asserted:
- WAIT lasts 8 cycles, then timeout_err=1.
- frame_done pulses; drawn_count=0.
- The next frame_start clears timeout_err.
REQ-038 class_count=20 with MAX_PER_CLASS=16, all active:
- exactly 16 draws for that class.
- a second frame_start during the pass is ignored.
REQ-039 reset asserted 2 cycles after a draw_start:
- next cycle busy=0, draw_start=0, drawn_count=0.
- a subsequent draw_done causes no activity.
REQ-040 draw_done and timer expiry coincident (TIMEOUT=4, done on 4th WAIT cycle):
- drawn_count increments.
- timeout_err stays 0.
